// File: rtl/simd_pkg.sv
// Shared types and sizing for the SIMD ALU sequencer.
package simd_pkg;

  localparam int unsigned OPCODE_WIDTH = 3;
  localparam int unsigned ADDR_WIDTH   = 10;
  localparam int unsigned LEN_WIDTH    = ADDR_WIDTH + 1;
  localparam int unsigned DATA_WIDTH   = 32;
  localparam int unsigned MEM_LATENCY  = 1;
  localparam int unsigned ALU_LATENCY  = 1;
  localparam int unsigned PIPE_DEPTH   = MEM_LATENCY + ALU_LATENCY;

  typedef enum logic [OPCODE_WIDTH-1:0] {
    NOOP          = 3'd0,
    ADD           = 3'd1,
    SUB           = 3'd2,
    MUL           = 3'd3,
    DOTP          = 3'd4,
    STORE_TEMP_S1 = 3'd5,
    STORE_TEMP_S2 = 3'd6,
    STORE_RESULT  = 3'd7
  } alu_op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_WB,
    S_DONE
  } seq_state_t;

  // Element tag travelling from the read stage to the write stage.
  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] idx;
  } pipe_tag_t;

  function automatic logic is_legal(alu_op_t op);
    return op inside {ADD, SUB, MUL, DOTP};
  endfunction

endpackage

// File: rtl/seq_delay_line.sv
// Shift register carrying element tags; exposes the valid bit of one
// intermediate stage and the full last stage.
module seq_delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1,
  parameter int unsigned TAP   = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] din,
  output logic             tap_valid,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0][WIDTH-1:0] stage;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stage <= '0;
    end else begin
      stage[0] <= din;
      for (int k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
    end
  end

  // Valid flag is the MSB of each stage.
  assign tap_valid = stage[TAP][WIDTH-1];
  assign dout      = stage[DEPTH-1];

endmodule

// File: rtl/alu_sequencer.sv
// Sequences the SIMD ALU over a vector command: element-wise ADD/SUB/MUL
// written back per element, or a DOTP reduction written once at the end.
module alu_sequencer
  import simd_pkg::*;
(
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [OPCODE_WIDTH-1:0] cmd_opcode,
  input  logic [LEN_WIDTH-1:0]    cmd_len,
  input  logic [ADDR_WIDTH-1:0]   cmd_src_a,
  input  logic [ADDR_WIDTH-1:0]   cmd_src_b,
  input  logic [ADDR_WIDTH-1:0]   cmd_dst,
  output logic                    rd_en,
  output logic [ADDR_WIDTH-1:0]   rd_addr_a,
  output logic [ADDR_WIDTH-1:0]   rd_addr_b,
  input  logic [DATA_WIDTH-1:0]   rd_data_a,
  input  logic [DATA_WIDTH-1:0]   rd_data_b,
  output logic [DATA_WIDTH-1:0]   alu_a,
  output logic [DATA_WIDTH-1:0]   alu_b,
  output logic [OPCODE_WIDTH-1:0] alu_opcode,
  input  logic [DATA_WIDTH-1:0]   alu_out,
  output logic                    wr_en,
  output logic [ADDR_WIDTH-1:0]   wr_addr,
  output logic [DATA_WIDTH-1:0]   wr_data,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int unsigned CNT_WIDTH = $clog2(PIPE_DEPTH) + 1;

  seq_state_t            state, state_n;
  alu_op_t               op, op_n;
  logic [LEN_WIDTH-1:0]  len, len_n, idx, idx_n;
  logic [ADDR_WIDTH-1:0] dst, dst_n, rd_addr_a_n, rd_addr_b_n;
  logic [CNT_WIDTH-1:0]  cnt, cnt_n;
  logic [DATA_WIDTH-1:0] acc, acc_n;
  logic                  rd_en_n, err_n;
  logic                  alu_valid, elem_wr, wb_wr;
  pipe_tag_t             tag_in, tag_out;

  assign tag_in = '{valid: rd_en, idx: ADDR_WIDTH'(idx)};

  seq_delay_line #(
    .WIDTH ($bits(pipe_tag_t)),
    .DEPTH (PIPE_DEPTH),
    .TAP   (MEM_LATENCY - 1)
  ) u_delay (
    .clk       (clk),
    .rstn      (rstn),
    .din       (tag_in),
    .tap_valid (alu_valid),
    .dout      (tag_out)
  );

  // Next-state and next-register logic.
  always_comb begin
    state_n     = state;
    op_n        = op;
    len_n       = len;
    dst_n       = dst;
    idx_n       = idx;
    cnt_n       = cnt;
    acc_n       = acc;
    rd_en_n     = 1'b0;
    rd_addr_a_n = '0;
    rd_addr_b_n = '0;
    err_n       = 1'b0;

    if (tag_out.valid && op == DOTP) acc_n = acc + alu_out;

    unique case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          op_n  = alu_op_t'(cmd_opcode);
          len_n = cmd_len;
          dst_n = cmd_dst;
          idx_n = '0;
          cnt_n = '0;
          acc_n = '0;
          if (!is_legal(op_n)) begin
            state_n = S_DONE;
            err_n   = 1'b1;
          end else if (cmd_len == '0) begin
            state_n = (op_n == DOTP) ? S_WB : S_DONE;
          end else begin
            state_n     = S_RUN;
            rd_en_n     = 1'b1;
            rd_addr_a_n = cmd_src_a;
            rd_addr_b_n = cmd_src_b;
          end
        end
      end
      S_RUN: begin
        if (idx == len - LEN_WIDTH'(1)) begin
          state_n = S_DRAIN;
          cnt_n   = '0;
        end else begin
          idx_n       = idx + LEN_WIDTH'(1);
          rd_en_n     = 1'b1;
          rd_addr_a_n = rd_addr_a + ADDR_WIDTH'(1);
          rd_addr_b_n = rd_addr_b + ADDR_WIDTH'(1);
        end
      end
      S_DRAIN: begin
        if (cnt == CNT_WIDTH'(PIPE_DEPTH - 1)) state_n = (op == DOTP) ? S_WB : S_DONE;
        else cnt_n = cnt + CNT_WIDTH'(1);
      end
      S_WB:    state_n = S_DONE;
      S_DONE: begin
        state_n = S_IDLE;
        op_n    = NOOP;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      op        <= NOOP;
      len       <= '0;
      dst       <= '0;
      idx       <= '0;
      cnt       <= '0;
      acc       <= '0;
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      op        <= op_n;
      len       <= len_n;
      dst       <= dst_n;
      idx       <= idx_n;
      cnt       <= cnt_n;
      acc       <= acc_n;
      rd_en     <= rd_en_n;
      rd_addr_a <= rd_addr_a_n;
      rd_addr_b <= rd_addr_b_n;
      cmd_ready <= (state_n == S_IDLE);
      busy      <= (state_n != S_IDLE);
      done      <= (state_n == S_DONE);
      err       <= err_n;
    end
  end

  // Operands and write-back track the element pipeline, so they follow
  // the memory and ALU data in the same cycle it becomes valid.
  assign alu_opcode = op;
  assign alu_a      = alu_valid ? rd_data_a : '0;
  assign alu_b      = alu_valid ? rd_data_b : '0;
  assign elem_wr    = tag_out.valid && (op != DOTP);
  assign wb_wr      = (state == S_WB);
  assign wr_en      = elem_wr || wb_wr;
  assign wr_addr    = wb_wr ? dst : (elem_wr ? dst + tag_out.idx : '0);
  assign wr_data    = wb_wr ? acc : (elem_wr ? alu_out : '0);

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with behavioural source memories, a
// one-cycle ALU, and read/write scoreboards filled when commands are issued.
module tb_alu_sequencer;
  import simd_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_opcode = '0;
  logic [10:0] cmd_len = '0;
  logic [9:0]  cmd_src_a = '0, cmd_src_b = '0, cmd_dst = '0;
  logic        rd_en;
  logic [9:0]  rd_addr_a, rd_addr_b;
  logic [31:0] rd_data_a = '0, rd_data_b = '0;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_opcode;
  logic [31:0] alu_out = '0;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;
  logic        busy, done, err;

  logic [31:0] mem_a [1024];
  logic [31:0] mem_b [1024];
  logic [19:0] rq [$];
  logic [41:0] wq [$];

  int checks = 0, errors = 0;
  int cyc = 0, acc_cyc = 0, done_cyc = 0, first_wr_lat = -1, last_wr_cyc = 0;

  alu_sequencer dut (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_len(cmd_len), .cmd_src_a(cmd_src_a),
    .cmd_src_b(cmd_src_b), .cmd_dst(cmd_dst), .rd_en(rd_en),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rd_data_a),
    .rd_data_b(rd_data_b), .alu_a(alu_a), .alu_b(alu_b),
    .alu_opcode(alu_opcode), .alu_out(alu_out), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd1:    return a + b;
      3'd2:    return a - b;
      3'd3,
      3'd4:    return a * b;
      default: return '0;
    endcase
  endfunction

  // One-cycle source memories and ALU.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_data_a <= mem_a[rd_addr_a];
      rd_data_b <= mem_b[rd_addr_b];
    end
    alu_out <= ref_op(alu_opcode, alu_a, alu_b);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Read/write monitor against the scoreboards.
  always @(negedge clk) begin
    if (rd_en) begin
      if (rq.size() == 0) chk("rd_unexpected", 64'(rd_en), 64'd0);
      else chk("rd_addr", 64'({rd_addr_a, rd_addr_b}), 64'(rq.pop_front()));
    end
    if (wr_en) begin
      if (wq.size() == 0) chk("wr_unexpected", 64'(wr_en), 64'd0);
      else chk("wr", 64'({wr_addr, wr_data}), 64'(wq.pop_front()));
      if (first_wr_lat < 0) first_wr_lat = cyc - acc_cyc + 1;
      last_wr_cyc = cyc;
    end
  end

  task automatic send(input alu_op_t op, input logic [10:0] len, input logic [9:0] sa,
                      input logic [9:0] sb, input logic [9:0] dst, input bit model);
    logic [31:0] acc, r;
    logic [9:0]  ai, bi;
    int          n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_opcode = op; cmd_len = len;
    cmd_src_a = sa; cmd_src_b = sb; cmd_dst = dst;
    if (model && (op inside {ADD, SUB, MUL, DOTP})) begin
      acc = '0;
      for (int i = 0; i < int'(len); i++) begin
        ai = sa + 10'(i);
        bi = sb + 10'(i);
        rq.push_back({ai, bi});
        r = ref_op(op, mem_a[ai], mem_b[bi]);
        if (op == DOTP) acc = acc + r;
        else wq.push_back({10'(dst + 10'(i)), r});
      end
      if (op == DOTP) wq.push_back({dst, acc});
    end
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    chk("cmd_ready", 64'(cmd_ready), 64'd1);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    first_wr_lat = -1;
    cmd_valid = 1'b0; cmd_opcode = '0; cmd_len = '0;
    cmd_src_a = '0; cmd_src_b = '0; cmd_dst = '0;
  endtask

  task automatic wait_done(input string tag, input int exp_lat, input logic exp_err, input alu_op_t exp_op);
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < 3000) begin @(negedge clk); n++; end
    done_cyc = cyc;
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_lat"}, 64'(cyc - acc_cyc + 1), 64'(exp_lat));
    chk({tag, "_err"}, 64'(err), 64'(exp_err));
    chk({tag, "_op"}, 64'(alu_opcode), 64'(exp_op));
    chk({tag, "_busy"}, 64'({cmd_ready, busy}), 64'b01);
    @(negedge clk);
    chk({tag, "_idle"}, 64'({done, err, cmd_ready, busy}), 64'b0010);
    chk({tag, "_sb"}, 64'(rq.size() + wq.size()), 64'd0);
  endtask

  initial begin
    int done_seen;
    for (int i = 0; i < 1024; i++) begin mem_a[i] = '0; mem_b[i] = '0; end

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_ctrl", 64'({cmd_ready, busy, done, err, rd_en, wr_en}), 64'b100000);
    chk("rst_op", 64'(alu_opcode), 64'(NOOP));
    chk("rst_addr", 64'({rd_addr_a, rd_addr_b, wr_addr}), 64'd0);
    chk("rst_alu", {alu_a, alu_b}, 64'd0);
    chk("rst_wdata", 64'(wr_data), 64'd0);
    rstn = 1'b1;

    // ADD N=4
    for (int i = 0; i < 4; i++) begin
      mem_a[i] = 32'(i + 1);
      mem_b[10'h200 + 10'(i)] = 32'(10 * (i + 1));
    end
    send(ADD, 11'd4, 10'h000, 10'h200, 10'h100, 1'b1);
    wait_done("add", 7, 1'b0, ADD);
    chk("add_first_wr", 64'(first_wr_lat), 64'd3);
    chk("add_wr_to_done", 64'(done_cyc - last_wr_cyc), 64'd1);

    // SUB N=2, negative results
    mem_a[10'h010] = 32'd5; mem_a[10'h011] = 32'd0;
    mem_b[10'h210] = 32'd7; mem_b[10'h211] = 32'd1;
    send(SUB, 11'd2, 10'h010, 10'h210, 10'h180, 1'b1);
    wait_done("sub", 5, 1'b0, SUB);

    // DOTP N=3
    for (int i = 0; i < 3; i++) begin
      mem_a[10'h020 + 10'(i)] = 32'(i + 1);
      mem_b[10'h220 + 10'(i)] = 32'(i + 4);
    end
    send(DOTP, 11'd3, 10'h020, 10'h220, 10'h020, 1'b1);
    wait_done("dotp", 7, 1'b0, DOTP);

    // Address wrap on reads and writes
    mem_a[10'h3FE] = 32'd3; mem_a[10'h3FF] = 32'd5;
    mem_b[10'h300] = 32'd7; mem_b[10'h301] = 32'd11;
    mem_b[10'h302] = 32'd13; mem_b[10'h303] = 32'd17;
    send(MUL, 11'd4, 10'h3FE, 10'h300, 10'h3FE, 1'b1);
    wait_done("wrap", 7, 1'b0, MUL);

    // Zero-length commands
    send(ADD, 11'd0, 10'h000, 10'h000, 10'h050, 1'b1);
    wait_done("add_n0", 1, 1'b0, ADD);
    send(DOTP, 11'd0, 10'h000, 10'h000, 10'h060, 1'b1);
    wait_done("dotp_n0", 2, 1'b0, DOTP);

    // Illegal opcode
    send(STORE_RESULT, 11'd4, 10'h000, 10'h000, 10'h070, 1'b1);
    wait_done("illegal", 1, 1'b1, STORE_RESULT);

    // Reset during RUN of an 8-element ADD
    send(ADD, 11'd8, 10'h040, 10'h240, 10'h300, 1'b0);
    rq.push_back({10'h040, 10'h240});
    rq.push_back({10'h041, 10'h241});
    @(negedge clk);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_ctrl", 64'({cmd_ready, busy, done, err, rd_en, wr_en}), 64'b100000);
    chk("mid_rst_alu", {alu_a, alu_b}, 64'd0);
    chk("mid_rst_addr", 64'({rd_addr_a, wr_addr, wr_data}), 64'd0);
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) done_seen++;
      if (i == 3) rstn = 1'b1;
    end
    chk("mid_rst_no_done", 64'(done_seen), 64'd0);
    chk("mid_rst_sb", 64'(rq.size() + wq.size()), 64'd0);

    // Command after reset: DOTP with 32-bit wrap of the accumulator
    mem_a[10'h050] = 32'hFFFF_FFFF; mem_a[10'h051] = 32'd2;
    mem_b[10'h250] = 32'd1;         mem_b[10'h251] = 32'd3;
    send(DOTP, 11'd2, 10'h050, 10'h250, 10'h010, 1'b1);
    wait_done("post_rst_dotp", 6, 1'b0, DOTP);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
